mem_frame_streamer: RTL and testbench

Reads a runtime-selected byte region from a synchronous memory (BRAM/DRAM port) and emits it as one AXI4-Stream frame per trigger.
It adds the following to the fixed-length streamer:
- runtime base address and length
- a configurable memory read latency
- full backpressure tolerance with no lost or duplicated words
- a partial-word tkeep on the last beat
- a loop (repeat) mode
It sits between a frame-template memory and a MAC/TX stream path, and is controlled by register-block pulses.

---
 rtl/mem_streamer_pkg.sv | 33 +++
 rtl/mem_streamer_fifo.sv | 55 +++++
 rtl/mem_frame_streamer.sv | 156 +++++++++++++++
 tb/tb_mem_frame_streamer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_streamer_pkg.sv
// mem_streamer_pkg: shared state encoding and sizing helpers
// for the memory frame streamer.
package mem_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  localparam int MAX_B = 128;

  function automatic logic [MAX_B-1:0] keep_mask(
    input int unsigned rem,
    input int unsigned b
  );
    logic [MAX_B-1:0] m;
    int unsigned n;
    n = (rem == 0) ? b : rem;
    m = '0;
    for (int unsigned i = 0; i < MAX_B; i++)
      if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic int unsigned ceil_div(
    input int unsigned n,
    input int unsigned d
  );
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/mem_streamer_fifo.sv
// mem_streamer_fifo: small first-word-fall-through FIFO;
// an empty FIFO passes the write straight to the read side.
module mem_streamer_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 3,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          empty, store, deq;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  assign valid_o = !empty || push_i;
  assign rdata_o = empty ? wdata_i : mem_q[rd_q];
  assign count_o = cnt_q;
  assign deq     = pop_i && !empty;
  // A word popped in the cycle it arrives is never stored.
  assign store   = push_i && !(empty && pop_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (store) wr_q <= nxt(wr_q);
      if (deq) rd_q <= nxt(rd_q);
      if (store && !deq) cnt_q <= cnt_q + 1'b1;
      else if (deq && !store) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/mem_frame_streamer.sv
// mem_frame_streamer: streams a runtime-selected memory region
// as AXI4-Stream frames, with credit-based read issue.
module mem_frame_streamer
  import mem_streamer_pkg::*;
#(
  parameter int addr_width  = 12,
  parameter int data_width  = 32,
  parameter int len_width   = 16,
  parameter int mem_latency = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [addr_width-1:0]   cfg_base,
  input  logic [len_width-1:0]    cfg_bytes,
  input  logic                    cfg_loop,
  input  logic                    start,
  input  logic                    stop,
  output logic                    busy,
  output logic                    done,
  output logic [addr_width-1:0]   mem_addr,
  output logic                    mem_en,
  input  logic [data_width-1:0]   mem_rdata,
  output logic [data_width-1:0]   m_axis_tdata,
  output logic [data_width/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);

  localparam int B = data_width / 8;
  localparam int unsigned BU = B;
  localparam int DEPTH = mem_latency + 2;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = data_width + B + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  state_e                state_q;
  logic [addr_width-1:0] base_q, addr_q;
  logic [len_width-1:0]  words_q, remain_q, words_c;
  logic [B-1:0]          lkeep_q;
  logic                  loop_q, stop_q;

  logic [mem_latency-1:0] vld_q, lst_q;
  logic [B-1:0]           kp_q [mem_latency];

  logic [CW-1:0] inflight, fcnt;
  logic [CW:0]   occ;
  logic          issue, last_w, stop_now;
  logic          f_valid, fire, fin;
  logic [B-1:0]  keep_w;
  logic [FW-1:0] f_rdata;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < mem_latency; i++)
      inflight = inflight + CW'(vld_q[i]);
  end

  // Credits cover both reads in flight and words parked in the FIFO.
  assign occ      = {1'b0, inflight} + {1'b0, fcnt};
  assign issue    = (state_q == RUN) && (remain_q != '0)
                 && (occ < DEPTH_W);
  assign last_w   = (remain_q == len_width'(1));
  assign keep_w   = last_w ? lkeep_q : '1;
  assign stop_now = stop_q || stop;
  assign words_c  = len_width'(ceil_div(32'(cfg_bytes), BU));
  assign fire     = f_valid && m_axis_tready;
  assign fin      = (state_q == DRAIN) && fire
                 && f_rdata[FW-1] && (occ == (CW + 1)'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      addr_q   <= '0;
      words_q  <= '0;
      remain_q <= '0;
      lkeep_q  <= '0;
      loop_q   <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && cfg_bytes != '0) begin
            base_q   <= cfg_base;
            addr_q   <= cfg_base;
            words_q  <= words_c;
            remain_q <= words_c;
            lkeep_q  <= B'(keep_mask(32'(cfg_bytes) % BU, BU));
            loop_q   <= cfg_loop;
            stop_q   <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (stop) stop_q <= 1'b1;
          if (issue) begin
            if (last_w && loop_q && !stop_now) begin
              addr_q   <= base_q;
              remain_q <= words_q;
            end else begin
              addr_q   <= addr_q + 1'b1;
              remain_q <= remain_q - 1'b1;
              if (last_w) state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (fin) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      lst_q <= '0;
      for (int i = 0; i < mem_latency; i++) kp_q[i] <= '0;
    end else begin
      vld_q[0] <= issue;
      lst_q[0] <= issue && last_w;
      kp_q[0]  <= keep_w;
      for (int i = 1; i < mem_latency; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
        kp_q[i]  <= kp_q[i-1];
      end
    end
  end

  mem_streamer_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (vld_q[mem_latency-1]),
    .wdata_i ({lst_q[mem_latency-1], kp_q[mem_latency-1], mem_rdata}),
    .pop_i   (m_axis_tready),
    .valid_o (f_valid),
    .rdata_o (f_rdata),
    .count_o (fcnt)
  );

  assign busy          = (state_q != IDLE);
  assign done          = fin;
  assign mem_en        = issue;
  assign mem_addr      = addr_q;
  assign m_axis_tvalid = f_valid;
  assign m_axis_tlast  = f_valid && f_rdata[FW-1];
  assign m_axis_tkeep  = f_valid ? f_rdata[FW-2:data_width] : '0;
  assign m_axis_tdata  = f_valid ? f_rdata[data_width-1:0] : '0;

endmodule

// File: tb/tb_mem_frame_streamer.sv
// tb_mem_frame_streamer: directed checks of the frame streamer
// at read latency 1 and 3, memory word[i] = i.
module tb_mem_frame_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] cfg_base;
  logic [15:0] cfg_bytes;
  logic        cfg_loop, start, stop;
  logic        rdy, sel;
  int          total = 0;
  int          bad = 0;
  int          first;

  logic        busy1, done1, en1, tv1, tl1, tr1;
  logic [11:0] a1;
  logic [31:0] rd1, td1;
  logic [3:0]  tk1;
  logic        busy3, done3, en3, tv3, tl3, tr3;
  logic [11:0] a3;
  logic [31:0] rd3, td3, p3a, p3b;
  logic [3:0]  tk3;

  logic        o_valid, o_last, o_busy, o_done;
  logic [3:0]  o_keep;
  logic [31:0] o_data;

  always #5 clk = ~clk;

  assign tr1 = sel ? 1'b1 : rdy;
  assign tr3 = sel ? rdy : 1'b1;

  always @(posedge clk) begin
    rd1 <= en1 ? {20'h0, a1} : 32'hDEAD_BEEF;
    p3a <= en3 ? {20'h0, a3} : 32'hDEAD_BEEF;
    p3b <= p3a;
    rd3 <= p3b;
  end

  assign o_valid = sel ? tv3 : tv1;
  assign o_last  = sel ? tl3 : tl1;
  assign o_keep  = sel ? tk3 : tk1;
  assign o_data  = sel ? td3 : td1;
  assign o_busy  = sel ? busy3 : busy1;
  assign o_done  = sel ? done3 : done1;

  mem_frame_streamer #(
    .addr_width(12), .data_width(32),
    .len_width(16), .mem_latency(1)
  ) u_l1 (
    .clk(clk), .rst(rst),
    .cfg_base(cfg_base), .cfg_bytes(cfg_bytes),
    .cfg_loop(cfg_loop), .start(start), .stop(stop),
    .busy(busy1), .done(done1),
    .mem_addr(a1), .mem_en(en1), .mem_rdata(rd1),
    .m_axis_tdata(td1), .m_axis_tkeep(tk1),
    .m_axis_tlast(tl1), .m_axis_tvalid(tv1),
    .m_axis_tready(tr1)
  );

  mem_frame_streamer #(
    .addr_width(12), .data_width(32),
    .len_width(16), .mem_latency(3)
  ) u_l3 (
    .clk(clk), .rst(rst),
    .cfg_base(cfg_base), .cfg_bytes(cfg_bytes),
    .cfg_loop(cfg_loop), .start(start), .stop(stop),
    .busy(busy3), .done(done3),
    .mem_addr(a3), .mem_en(en3), .mem_rdata(rd3),
    .m_axis_tdata(td3), .m_axis_tkeep(tk3),
    .m_axis_tlast(tl3), .m_axis_tvalid(tv3),
    .m_axis_tready(tr3)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [11:0] b,
                          input logic [15:0] n,
                          input logic lp);
    @(negedge clk);
    cfg_base = b; cfg_bytes = n; cfg_loop = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_frame(input logic [11:0] b, input int n,
                              input int pct, input int nfr,
                              input int stop_at, output int fst);
    int words, k, f, acc, it;
    logic [3:0]  lk;
    logic [11:0] ea;
    logic [36:0] hold;
    bit stalled, sent, exp_done, lastb;
    words = (n + 3) / 4;
    lk = (n % 4 == 0) ? 4'hF : 4'((1 << (n % 4)) - 1);
    k = 0; f = 0; acc = 0; it = 0; fst = -1;
    stalled = 0; sent = 0; hold = '0;
    while (f < nfr && it < 3000) begin
      @(negedge clk);
      rdy = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      stop = 1'b0;
      if (!sent && acc == stop_at) begin
        stop = 1'b1; sent = 1;
      end
      #1;
      it++;
      lastb = (k == words - 1);
      if (stalled)
        chk("hold", {o_valid, o_last, o_keep, o_data}, {1'b1, hold});
      exp_done = o_valid && rdy && lastb && (f == nfr - 1);
      chk("done", o_done, exp_done);
      if (o_valid && fst < 0) fst = it;
      if (o_valid && rdy) begin
        ea = b + 12'(k);
        chk("data", o_data, {20'h0, ea});
        chk("keep", o_keep, lastb ? lk : 4'hF);
        chk("last", o_last, lastb);
        acc++; k++;
        if (k == words) begin k = 0; f++; end
        stalled = 0;
      end else begin
        stalled = o_valid;
        hold = {o_last, o_keep, o_data};
      end
    end
    stop = 1'b0;
    chk("timeout", it < 3000, 1'b1);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    rdy = 1'b1;
    #1;
    chk({tag, " busy"}, o_busy, 1'b0);
    chk({tag, " tvalid"}, o_valid, 1'b0);
    chk({tag, " done"}, o_done, 1'b0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_loop = 1'b0;
    cfg_base = '0; cfg_bytes = '0; rdy = 1'b1; sel = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst busy", busy1, 1'b0);
    chk("rst done", done1, 1'b0);
    chk("rst mem_en", en1, 1'b0);
    chk("rst tvalid", tv1, 1'b0);
    chk("rst tlast", tl1, 1'b0);
    chk("rst mem_addr", a1, 12'h0);
    chk("rst tdata", td1, 32'h0);
    chk("rst tkeep", tk1, 4'h0);
    chk("rst tvalid l3", tv3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 16 bytes from 0x10, latency 1
    do_start(12'h010, 16'd16, 1'b0);
    #1;
    chk("t1 busy", busy1, 1'b1);
    chk("t1 mem_en", en1, 1'b1);
    chk("t1 mem_addr", a1, 12'h010);
    chk("t1 early tvalid", tv1, 1'b0);
    expect_frame(12'h010, 16, 100, 1, -1, first);
    chk("t1 latency", first, 1);
    check_idle("t1");

    // 7 bytes: partial keep on the last beat
    do_start(12'h040, 16'd7, 1'b0);
    expect_frame(12'h040, 7, 100, 1, -1, first);
    check_idle("t2");

    // address wrap
    do_start(12'hFFF, 16'd12, 1'b0);
    expect_frame(12'hFFF, 12, 100, 1, -1, first);
    check_idle("t5");

    // loop of 2-word frames, stop while beat 4 is presented
    do_start(12'h080, 16'd8, 1'b1);
    expect_frame(12'h080, 8, 100, 3, 4, first);
    check_idle("t4");
    check_idle("t4b");
    repeat (20) @(negedge clk);

    // latency 3 with 30% ready
    sel = 1'b1;
    do_start(12'h020, 16'd64, 1'b0);
    expect_frame(12'h020, 64, 30, 1, -1, first);
    check_idle("t3");
    repeat (20) @(negedge clk);
    sel = 1'b0;

    // zero length start
    do_start(12'h123, 16'd0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("t6 zero busy", busy1, 1'b0);
      chk("t6 zero mem_en", en1, 1'b0);
      chk("t6 zero tvalid", tv1, 1'b0);
    end

    // second start while busy is ignored
    rdy = 1'b0;
    do_start(12'h100, 16'd16, 1'b0);
    do_start(12'h200, 16'd4, 1'b0);
    expect_frame(12'h100, 16, 100, 1, -1, first);
    check_idle("t6 busy");
    check_idle("t6 busy2");
    repeat (20) @(negedge clk);

    // reset mid-frame, then restart
    do_start(12'h300, 16'd32, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("t6 pre tvalid", tv1, 1'b1);
    rst = 1'b0;
    #1;
    chk("t6 rst tvalid", tv1, 1'b0);
    chk("t6 rst busy", busy1, 1'b0);
    chk("t6 rst mem_en", en1, 1'b0);
    chk("t6 rst tdata", td1, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    do_start(12'h050, 16'd8, 1'b0);
    expect_frame(12'h050, 8, 100, 1, -1, first);
    chk("t6 restart latency", first, 1);
    check_idle("t6 end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
